// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter
//
// Purpose:
//   Shares a single data-memory port between num_req_p requesters. An idle
//   arbiter picks the first valid requester at or after the round-robin
//   pointer and accepts it in the same cycle. It then presents the latched
//   command to memory until the memory accepts it. For reads, it waits for read
//   data and forwards it to the granted requester as a one-cycle response.
//   A watchdog ends a read that never returns data. It raises a sticky error
//   and sends a zero-data response instead.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req_valid_i     per-requester request valid
//   req_we_i        per-requester write enable
//   req_addr_i      packed addresses, slot k at [k*addr_width_p +: addr_width_p]
//   req_wdata_i     packed write data, same packing
//   req_ready_o     one-hot accept pulse
//   resp_valid_o    one-hot read-response pulse
//   resp_data_o     read data shared by all requesters (holds between pulses)
//   mem_*_o         command to the data memory
//   mem_ready_i     memory accepts the command
//   mem_rvalid_i    memory read data valid
//   mem_rdata_i     memory read data
//   error_o         sticky read-timeout flag
//   grant_id_o      index of the current / last granted requester
module dmem_rr_arbiter #(
    parameter int num_req_p    = 4,
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int timeout_p    = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [num_req_p-1:0]              req_valid_i,
    input  logic [num_req_p-1:0]              req_we_i,
    input  logic [num_req_p*addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p*data_width_p-1:0] req_wdata_i,
    output logic [num_req_p-1:0]              req_ready_o,
    output logic [num_req_p-1:0]              resp_valid_o,
    output logic [data_width_p-1:0]           resp_data_o,
    output logic                              mem_valid_o,
    output logic                              mem_we_o,
    output logic [addr_width_p-1:0]           mem_addr_o,
    output logic [data_width_p-1:0]           mem_wdata_o,
    input  logic                              mem_ready_i,
    input  logic                              mem_rvalid_i,
    input  logic [data_width_p-1:0]           mem_rdata_i,
    output logic                              error_o,
    output logic [2:0]                        grant_id_o
);

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_ISSUE   = 2'd1;
    localparam logic [1:0] STATE_WAIT_RD = 2'd2;

    localparam logic [2:0] LAST_SLOT = 3'(num_req_p - 1);
    localparam logic [7:0] TIMEOUT   = 8'(timeout_p);

    logic [1:0]              state_q, state_d;
    logic [2:0]              rr_ptr_q, rr_ptr_d;
    logic [2:0]              grant_q, grant_d;
    logic                    we_q, we_d;
    logic [addr_width_p-1:0] addr_q, addr_d;
    logic [data_width_p-1:0] wdata_q, wdata_d;
    logic [7:0]              timer_q, timer_d;
    logic                    error_q, error_d;
    logic [num_req_p-1:0]    resp_valid_q, resp_valid_d;
    logic [data_width_p-1:0] resp_data_q, resp_data_d;

    logic                    hi_found, lo_found, sel_found;
    logic [2:0]              hi_idx, lo_idx, sel_idx;
    logic                    sel_we;
    logic [addr_width_p-1:0] sel_addr;
    logic [data_width_p-1:0] sel_wdata;
    logic [num_req_p-1:0]    grant_onehot;
    logic [2:0]              ptr_after_grant;

    // Round-robin pick. The lowest valid slot at or above the pointer wins.
    // Otherwise the search wraps to the lowest valid slot below the pointer.
    // The descending loop leaves the lowest index in each half.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            if (req_valid_i[k]) begin
                if (3'(k) >= rr_ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(k);
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = 3'(k);
                end
            end
        end
        sel_found = hi_found | lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Command fields of the selected slot, plus the one-hot forms of the
    // selection and of the current grant.
    always_comb begin
        sel_we       = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        req_ready_o  = '0;
        grant_onehot = '0;
        for (int k = 0; k < num_req_p; k++) begin
            if (3'(k) == sel_idx) begin
                sel_we    = req_we_i[k];
                sel_addr  = req_addr_i[k*addr_width_p +: addr_width_p];
                sel_wdata = req_wdata_i[k*data_width_p +: data_width_p];
            end
            req_ready_o[k]  = (state_q == STATE_IDLE) && sel_found &&
                              (3'(k) == sel_idx) && !reset;
            grant_onehot[k] = (3'(k) == grant_q);
        end
        ptr_after_grant = (grant_q == LAST_SLOT) ? 3'd0 : grant_q + 3'd1;
    end

    // Transaction sequencing. The pointer only moves once a transaction
    // completes. Only one transaction is in flight, so this gives the same
    // order as advancing it at accept time.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timer_d      = timer_q;
        error_d      = error_q;
        resp_valid_d = '0;
        resp_data_d  = resp_data_q;
        case (state_q)
            STATE_IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    state_d = STATE_ISSUE;
                end
            end
            STATE_ISSUE: begin
                if (mem_ready_i) begin
                    if (we_q) begin
                        rr_ptr_d = ptr_after_grant;
                        state_d  = STATE_IDLE;
                    end else begin
                        timer_d  = '0;
                        state_d  = STATE_WAIT_RD;
                    end
                end
            end
            STATE_WAIT_RD: begin
                // Real data takes priority over the watchdog in the final cycle.
                if (mem_rvalid_i) begin
                    resp_valid_d = grant_onehot;
                    resp_data_d  = mem_rdata_i;
                    rr_ptr_d     = ptr_after_grant;
                    state_d      = STATE_IDLE;
                end else if (timer_q == TIMEOUT) begin
                    error_d      = 1'b1;
                    resp_valid_d = grant_onehot;
                    resp_data_d  = '0;
                    rr_ptr_d     = ptr_after_grant;
                    state_d      = STATE_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State registers. Reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= STATE_IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            timer_q      <= '0;
            error_q      <= 1'b0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            error_q      <= error_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign mem_valid_o  = (state_q == STATE_ISSUE);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign error_o      = error_q;
    assign grant_id_o   = grant_q;

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// tb_dmem_rr_arbiter
//
// Purpose:
//   Drives random and directed requests into dmem_rr_arbiter and emulates
//   the data memory. A reference model accepts requests round-robin and
//   computes read data from its own copy of memory. At acceptance, the
//   model pushes the expected memory command and the expected response
//   into queues. A monitor pops those queues and compares them whenever
//   the DUT shows a command or a response.
module tb_dmem_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready_o, resp_valid_o;
    logic [DW-1:0]   resp_data_o;
    logic            mem_valid_o, mem_we_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_ready, mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            error_o;
    logic [2:0]      grant_id_o;

    dmem_rr_arbiter #(
        .num_req_p   (N),
        .addr_width_p(AW),
        .data_width_p(DW),
        .timeout_p   (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_ready_o (req_ready_o),
        .resp_valid_o(resp_valid_o),
        .resp_data_o (resp_data_o),
        .mem_valid_o (mem_valid_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready),
        .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i (mem_rdata),
        .error_o     (error_o),
        .grant_id_o  (grant_id_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } cmd_t;

    typedef struct {
        int          slot;
        logic [31:0] data;
        bit          tmo;
    } rsp_t;

    int n_checks = 0;
    int n_fails  = 0;

    // Requester side: a request stays posted until the model sees it accepted.
    bit          pending [N];
    bit          p_we    [N];
    logic [31:0] p_addr  [N];
    logic [31:0] p_wdata [N];

    // Stimulus knobs. force_lat: -2 random, -1 memory never answers, >=0 fixed.
    int req_pct     = 0;
    int we_pct      = 50;
    int rdy_pct     = 100;
    int norsp_pct   = 0;
    int force_lat   = -2;
    bit force_rvalid = 1'b0;

    // Reference model state.
    int          ref_ptr   = 0;
    int          cur_grant = 0;
    bit          busy      = 1'b0;
    bit          issuing   = 1'b0;
    bit          ref_err   = 1'b0;
    bit          rsp_armed = 1'b0;
    longint      rsp_due   = 0;
    longint      cycle     = 0;
    logic [31:0] last_data = '0;
    logic [31:0] ref_mem  [32];
    logic [31:0] fake_mem [32];
    cmd_t        cmd_q[$];
    rsp_t        rsp_q[$];

    // Emulated memory read: -1 idle, otherwise cycles until rvalid.
    int rd_wait = -1;
    int rd_idx  = 0;

    task automatic expectEq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int s);
        logic [N-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    function automatic bit pendingAny();
        bit any;
        any = 1'b0;
        for (int k = 0; k < N; k++) any |= pending[k];
        return any;
    endfunction

    task automatic setReq(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        pending[k] = 1'b1;
        p_we[k]    = we;
        p_addr[k]  = addr;
        p_wdata[k] = wdata;
    endtask

    // Drives requesters and the emulated memory for one cycle (at negedge).
    task automatic applyStimulus();
        for (int k = 0; k < N; k++) begin
            if (!pending[k] && ($urandom_range(99) < 32'(req_pct))) begin
                setReq(k, $urandom_range(99) < 32'(we_pct),
                       {25'd0, 5'($urandom_range(31)), 2'b00}, $urandom);
            end
            req_valid[k]              = pending[k];
            req_we[k]                 = p_we[k];
            req_addr[k*AW +: AW]      = p_addr[k];
            req_wdata[k*DW +: DW]     = p_wdata[k];
        end
        mem_ready  = $urandom_range(99) < 32'(rdy_pct);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        if (rd_wait == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = fake_mem[rd_idx];
            rd_wait    = -1;
        end else if (rd_wait > 0) begin
            rd_wait--;
        end
        if (force_rvalid) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hBAD0_0BAD;
        end
    endtask

    // Monitor body for one cycle: responses, memory command, then arbitration.
    task automatic checkOutput();
        bit           busy_start;
        int           exp_slot;
        int           c;
        int           lat;
        logic [N-1:0] exp_ready;
        cmd_t         cm;
        rsp_t         r;
        cycle++;

        if (resp_valid_o != '0) begin
            if (rsp_q.size() == 0) begin
                expectEq("resp_unexpected", 64'(resp_valid_o), 64'(0));
            end else begin
                r = rsp_q.pop_front();
                expectEq("resp_slot", 64'(resp_valid_o), 64'(onehot(r.slot)));
                expectEq("resp_data", 64'(resp_data_o), 64'(r.data));
                expectEq("resp_cycle", 64'(cycle), 64'(rsp_due));
                if (r.tmo) ref_err = 1'b1;
                last_data = r.data;
                busy      = 1'b0;
                rsp_armed = 1'b0;
                ref_ptr   = (r.slot + 1) % N;
            end
        end else begin
            expectEq("resp_data_hold", 64'(resp_data_o), 64'(last_data));
            if (rsp_armed && cycle > rsp_due) begin
                r = rsp_q.pop_front();
                expectEq("resp_missing", 64'(resp_valid_o), 64'(onehot(r.slot)));
                busy      = 1'b0;
                rsp_armed = 1'b0;
                ref_ptr   = (r.slot + 1) % N;
            end
        end
        expectEq("error", 64'(error_o), 64'(ref_err));

        busy_start = busy;
        if (busy_start) expectEq("grant_id", 64'(grant_id_o), 64'(cur_grant));

        expectEq("mem_valid", 64'(mem_valid_o), 64'(issuing));
        if (issuing && mem_valid_o && cmd_q.size() > 0) begin
            cm = cmd_q[0];
            expectEq("mem_we", 64'(mem_we_o), 64'(cm.we));
            expectEq("mem_addr", 64'(mem_addr_o), 64'(cm.addr));
            expectEq("mem_wdata", 64'(mem_wdata_o), 64'(cm.wdata));
            if (mem_ready) begin
                void'(cmd_q.pop_front());
                issuing = 1'b0;
                if (cm.we) begin
                    fake_mem[mem_addr_o[6:2]] = mem_wdata_o;
                    busy    = 1'b0;
                    ref_ptr = (cur_grant + 1) % N;
                end else begin
                    rd_wait   = cm.lat;
                    rd_idx    = int'(mem_addr_o[6:2]);
                    rsp_armed = 1'b1;
                    rsp_due   = cycle + 2 + ((cm.lat < 0) ? TO : cm.lat);
                end
            end
        end

        if (!busy_start) begin
            exp_slot = -1;
            for (int i = 0; i < N; i++) begin
                c = (ref_ptr + i) % N;
                if (exp_slot < 0 && req_valid[c]) exp_slot = c;
            end
            exp_ready = (exp_slot >= 0) ? onehot(exp_slot) : '0;
            expectEq("req_ready", 64'(req_ready_o), 64'(exp_ready));
            if (exp_slot >= 0) begin
                pending[exp_slot] = 1'b0;
                busy      = 1'b1;
                issuing   = 1'b1;
                cur_grant = exp_slot;
                if (force_lat == -2)
                    lat = ($urandom_range(99) < 32'(norsp_pct)) ? -1 : int'($urandom_range(TO));
                else
                    lat = force_lat;
                cm.we    = p_we[exp_slot];
                cm.addr  = p_addr[exp_slot];
                cm.wdata = p_wdata[exp_slot];
                cm.lat   = lat;
                cmd_q.push_back(cm);
                if (cm.we) begin
                    ref_mem[cm.addr[6:2]] = cm.wdata;
                end else begin
                    r.slot = exp_slot;
                    r.tmo  = (lat < 0);
                    r.data = (lat < 0) ? 32'd0 : ref_mem[cm.addr[6:2]];
                    rsp_q.push_back(r);
                end
            end
        end else begin
            expectEq("req_ready_busy", 64'(req_ready_o), 64'(0));
        end
    endtask

    always begin
        @(negedge clk);
        #4;
        if (!reset) checkOutput();
    end

    task automatic runCycles(input int n);
        repeat (n) begin
            @(negedge clk);
            applyStimulus();
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_pct = 0;
        while ((busy || pendingAny()) && n < 200) begin
            runCycles(1);
            n++;
        end
        if (n >= 200) expectEq("drain_timeout", 64'(busy), 64'(0));
        runCycles(1);
    endtask

    task automatic checkAllZero(input string tag);
        expectEq({tag, "_req_ready"}, 64'(req_ready_o), 64'(0));
        expectEq({tag, "_resp_valid"}, 64'(resp_valid_o), 64'(0));
        expectEq({tag, "_resp_data"}, 64'(resp_data_o), 64'(0));
        expectEq({tag, "_mem_valid"}, 64'(mem_valid_o), 64'(0));
        expectEq({tag, "_mem_we"}, 64'(mem_we_o), 64'(0));
        expectEq({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(0));
        expectEq({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'(0));
        expectEq({tag, "_error"}, 64'(error_o), 64'(0));
        expectEq({tag, "_grant_id"}, 64'(grant_id_o), 64'(0));
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 32; i++) begin
            v           = $urandom;
            ref_mem[i]  = v;
            fake_mem[i] = v;
        end
        for (int k = 0; k < N; k++) begin
            pending[k] = 1'b0;
            p_we[k]    = 1'b0;
            p_addr[k]  = '0;
            p_wdata[k] = '0;
        end
        reset = 1'b1;
        runCycles(3);
        #4;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus();

        // Single read from slot 2, memory answers one cycle after handshake.
        force_lat = 0;
        setReq(2, 1'b0, 32'h40, 32'h0);
        drain();
        force_lat = -2;

        // Every slot writing continuously with memory always ready.
        req_pct = 100; we_pct = 100; rdy_pct = 100;
        runCycles(24);
        drain();

        // Backpressure: slot 1 write held for several cycles, slot 3 waits.
        rdy_pct = 0;
        setReq(1, 1'b1, 32'h8, 32'h1234);
        runCycles(1);
        setReq(3, 1'b0, 32'h10, 32'h0);
        runCycles(5);
        rdy_pct = 100;
        drain();

        // Wrap: slot 2 alone moves the pointer to 3, then slots 0 and 3 race.
        setReq(2, 1'b1, 32'h20, 32'hA5A5_0002);
        drain();
        setReq(0, 1'b1, 32'h24, 32'hA5A5_0000);
        setReq(3, 1'b1, 32'h28, 32'hA5A5_0003);
        drain();

        // Timeout, then a normal read must still be served.
        force_lat = -1;
        setReq(1, 1'b0, 32'h2C, 32'h0);
        drain();
        force_lat = -2;
        setReq(3, 1'b0, 32'h28, 32'h0);
        drain();

        // Random traffic with backpressure, variable latency and timeouts.
        req_pct = 40; we_pct = 50; rdy_pct = 70; norsp_pct = 10;
        runCycles(1500);
        drain();

        // Asynchronous reset while waiting for read data.
        force_lat = -1;
        setReq(2, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 20 && !rsp_armed; i++) runCycles(1);
        if (!rsp_armed) expectEq("reach_wait_rd", 64'(rsp_armed), 64'(1));
        runCycles(1);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        cmd_q.delete();
        rsp_q.delete();
        busy = 1'b0; issuing = 1'b0; rsp_armed = 1'b0; ref_err = 1'b0;
        ref_ptr = 0; cur_grant = 0; last_data = '0; rd_wait = -1;
        force_lat = -2;
        runCycles(1);
        @(negedge clk);
        reset = 1'b0;
        force_rvalid = 1'b1;
        applyStimulus();
        force_rvalid = 1'b0;
        runCycles(3);
        setReq(2, 1'b1, 32'h30, 32'h0000_0222);
        setReq(0, 1'b1, 32'h34, 32'h0000_0111);
        drain();

        req_pct = 50; rdy_pct = 80; norsp_pct = 5;
        runCycles(400);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dmem_rr_arbiter.md
Name: dmem_rr_arbiter

Overview:
- Shares one data-memory port between num_req_p core_flattened instances, one per requester slot.
- Requests are granted round-robin.
- One transaction is outstanding at a time.
- Read data is returned to the granting requester.
- A watchdog flags a memory that never returns read data.
- Sits between the cores' data-memory request/response signals and the single data memory.

Parameters:
num_req_p, 4, number of requesters (2..8)
addr_width_p, 32, address width
data_width_p, 32, data width
timeout_p, 255, max cycles waited in WAIT_RD before error (8-bit compare)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid_i  input  num_req_p  per-requester request valid
req_we_i  input  num_req_p  per-requester write enable (1 = write)
req_addr_i  input  num_req_p*addr_width_p  addresses; slot k at bits [k*aw +: aw]
req_wdata_i  input  num_req_p*data_width_p  write data, same packing
req_ready_o  output  num_req_p  one-hot accept pulse
resp_valid_o  output  num_req_p  one-hot read-response pulse
resp_data_o  output  data_width_p  read data, shared by all requesters
mem_valid_o  output  1  memory command valid
mem_we_o  output  1  memory write enable
mem_addr_o  output  addr_width_p  memory address
mem_wdata_o  output  data_width_p  memory write data
mem_ready_i  input  1  memory accepts command
mem_rvalid_i  input  1  memory read data valid
mem_rdata_i  input  data_width_p  memory read data
error_o  output  1  sticky timeout flag
grant_id_o  output  3  index of current/last granted requester (debug)

Behaviour:
- Reset (async, active-high): state=IDLE, rr_ptr=0, grant_id_o=0, latched command=0, timer=0. All outputs 0.
- Reset mid-transaction abandons it; no response is produced.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Selection is combinational: the first k with req_valid_i[k]=1, searching rr_ptr, rr_ptr+1, … and wrapping mod num_req_p.
  - If such a k exists: req_ready_o[k]=1 in this cycle; latch we/addr/wdata of slot k; grant_id_o<=k; next state ISSUE.
  - If none: stay in IDLE; req_ready_o=0.
- ISSUE:
  - mem_valid_o=1; mem_we_o/addr/wdata come from the latched command and hold stable until the handshake.
  - Handshake occurs when mem_valid_o & mem_ready_i.
  - Write handshake: rr_ptr<=(grant+1) mod num_req_p; next state IDLE.
  - Read handshake: timer<=0; next state WAIT_RD.
  - mem_ready_i low: stay in ISSUE indefinitely (no timeout in ISSUE).
- WAIT_RD:
  - mem_valid_o=0; timer increments each cycle.
  - mem_rvalid_i=1: registered response. Next cycle resp_valid_o[grant]=1 for exactly one cycle and resp_data_o=mem_rdata_i. rr_ptr<=grant+1 mod num_req_p; next state IDLE.
  - timer==timeout_p with no rvalid: error_o<=1 (sticky until reset); resp_valid_o[grant] pulses with resp_data_o=0; rr_ptr advances; next state IDLE.
  - mem_rvalid_i outside WAIT_RD is ignored. It is only sampled from the cycle after the read handshake.
- resp_data_o holds its last value when resp_valid_o=0.
- Latency:
  - Grant to mem_valid_o: 1 cycle.
  - Best-case write: 2 cycles from accept back to IDLE.
  - Best-case read: accept at t, handshake at t+1, rvalid at t+2, resp_valid_o at t+3.
  - The next grant is possible in the cycle after returning to IDLE.
- Fairness: a requester is granted at most once per num_req_p grants while others are continuously requesting. No starvation.
- Requesters must hold req_* stable until req_ready_o. Requests dropped before accept are legal and simply not granted.
- grant_id_o is zero-extended to 3 bits.

Test Plan:
- Single read: slot 2 reads addr 0x40; memory ready=1, rdata 0xDEADBEEF one cycle after handshake → req_ready_o=0100 at t, mem_valid_o at t+1, resp_valid_o=0100 with data 0xDEADBEEF at t+3.
- Round-robin: all 4 slots request writes continuously with mem_ready_i=1 → grant order 0,1,2,3,0; req_ready_o pulses every 2 cycles.
- Backpressure: slot 1 writes 0x1234 to 0x8; mem_ready_i low for 5 cycles → mem_valid_o high and addr/wdata stable for 6 cycles; slot 3 request meanwhile is not accepted.
- Wrap/priority: rr_ptr=3, slots 0 and 3 request → slot 3 granted first, then slot 0.
- Timeout: read with timeout_p=4, no rvalid → error_o=1 after 4 WAIT_RD cycles; resp_valid_o pulses with data 0; next request is still served.
- Async reset mid-read (in WAIT_RD) → all outputs 0 immediately; late rvalid is ignored; first grant after reset goes to slot 0.
